contador_regressivo_bcd: RTL and testbench
==========================================

// Module: contador_regressivo_bcd
// PURPOSE
//  Two-digit BCD countdown timer that consumes the preset digits produced by the preset generator
//  (units 4 bit, tens 2 bit) and counts down to 00 once per prescaled tick.
//  Signals expiry so the traffic-light state controller can advance estado.
//  Displayed digits drive the 7-segment decoders directly.
// PARAMETERS
//  TICK_DIV  50_000_000  clock cycles per count step; must be >= 1; 1 means decrement every cycle
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  carrega      in   1  load strobe: capture presets and start counting
//  unid_preset  in   4  units preset digit (BCD)
//  dez_preset   in   2  tens preset digit (0..3)
//  unid         out  4  current units digit
//  dez          out  2  current tens digit
//  ocupado      out  1  high while in state CONTANDO
//  fim          out  1  one-cycle pulse: count reached 00
//  pausa        in   1  freeze count (present only with PAUSA_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): unid=0, dez=0, ocupado=0, fim=0, FSM=OCIOSO, prescaler=0.
//  FSM states: OCIOSO, CONTANDO, FIM.
//   OCIOSO   -> CONTANDO on carrega
//   CONTANDO -> FIM when the value becomes 00 on a tick; -> CONTANDO (reload) on carrega
//   FIM      -> OCIOSO next cycle; -> CONTANDO on carrega
//  Load: carrega=1 at edge N -> unid/dez hold presets, ocupado=1 after edge N. carrega beats tick.
//   unid_preset > 9 is loaded as 9. Prescaler cleared on load.
//   Preset 00: load enters CONTANDO; the first tick enters FIM without decrementing.
//  Prescaler: counts 0..TICK_DIV-1 only in CONTANDO; tick on the cycle it equals TICK_DIV-1, then wraps to 0.
//  Decrement on tick: unid>0 -> unid-1; unid=0 and dez>0 -> unid=9, dez-1; 00 -> FSM=FIM.
//   Digits never wrap below 00. Max value 39.
//  fim: high exactly one cycle while FSM=FIM, in the cycle after 00 is detected on a tick.
//   fim=0 when carrega arrives in the same edge.
//  ocupado = (FSM==CONTANDO). Digits hold their last value in OCIOSO/FIM (00 after an expiry).
//  Reset mid-count: immediate return to reset values. Prescaler restarts at 0.
// CONFIGURATION
//  PAUSA_EN defined: port pausa exists. pausa=1 in CONTANDO freezes the prescaler and digits.
//   FSM stays in CONTANDO and ocupado stays 1. carrega still loads while paused.
//  PAUSA_EN undefined: no pausa port. Counting is never frozen.
// STRUCTURE
//  Shared package (semaforo_pkg):
//   FSM state typedef {OCIOSO, CONTANDO, FIM}
//   BCD_MAX_UNID=4'd9
//   estado encodings shared with the preset generator
//  Sub-module gerador_tick: TICK_DIV prescaler.
//   Inputs: clk, rst_n, clear, enable. Output: tick.
//  Top holds the FSM and the BCD digit registers.
// TESTING (TICK_DIV=4 unless noted)
//  Reset: assert rst_n=0 mid-count -> unid=0, dez=0, ocupado=0, fim=0 with no clock edge.
//  Load 2/5 then wait 25 ticks -> sequence 25,24..20,19..00. fim=1 exactly once. ocupado falls with FSM entering FIM.
//  Borrow: load 1/0, 1 tick -> 09. Load unid_preset=4'hC, dez=1 -> 19.
//  Preset 00: load 0/0 -> first tick (cycle 4) FSM=FIM, fim pulse, digits stay 00.
//  Reload while counting: carrega at value 13 on the same edge as a tick, preset 3/0 -> 30 with no decrement.
//   Prescaler restarts, so the next decrement is 4 cycles later.
//  PAUSA_EN: pausa=1 for 10 cycles at value 07 -> holds 07, ocupado=1. Release -> 06 after 4 cycles.
//  TICK_DIV=1: load 0/3 -> 02,01,00 on consecutive cycles, then fim pulse.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared traffic-light types: countdown FSM states, BCD limits and estado encodings.
// No logic; latency n/a.
// Backpressure n/a.
package semaforo_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        FIM      = 2'd2
    } estado_cont_t;

    // Light phases, encoded identically in the preset generator.
    typedef enum logic [1:0] {
        VERDE    = 2'd0,
        AMARELO  = 2'd1,
        VERMELHO = 2'd2
    } estado_t;

    localparam logic [3:0] BCD_MAX_UNID = 4'd9;
    localparam logic [1:0] BCD_MAX_DEZ  = 2'd3;

    function automatic logic [3:0] sat_unid(input logic [3:0] d);
        return (d > BCD_MAX_UNID) ? BCD_MAX_UNID : d;
    endfunction

endpackage

// File: rtl/contador_regressivo_bcd_if.sv
// Load/preset/display bundle between the controller and the BCD countdown timer.
// Wires only; latency n/a.
// Backpressure: none, the timer always accepts carrega. Optional pausa exists with PAUSA_EN.
interface contador_regressivo_bcd_if;
    logic       carrega;
    logic [3:0] unid_preset;
    logic [1:0] dez_preset;
    logic [3:0] unid;
    logic [1:0] dez;
    logic       ocupado;
    logic       fim;
`ifdef PAUSA_EN
    logic       pausa;

    modport master (
        output carrega, unid_preset, dez_preset, pausa,
        input  unid, dez, ocupado, fim
    );
    modport slave (
        input  carrega, unid_preset, dez_preset, pausa,
        output unid, dez, ocupado, fim
    );
`else
    modport master (
        output carrega, unid_preset, dez_preset,
        input  unid, dez, ocupado, fim
    );
    modport slave (
        input  carrega, unid_preset, dez_preset,
        output unid, dez, ocupado, fim
    );
`endif
endinterface

// File: rtl/contador_regressivo_bcd_gerador_tick.sv
// Prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Tick is combinational on the cycle the count equals TICK_DIV-1.
// Backpressure: enable=0 freezes the count; clear restarts it at 0.
module gerador_tick #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == ULTIMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/contador_regressivo_bcd.sv
// Two-digit BCD countdown timer (00..39); pulses fim one tick after reaching 00. Optional PAUSA_EN adds a freeze input.
// Load visible one cycle after carrega; one decrement per TICK_DIV cycles.
// Backpressure: none; carrega always wins over a tick, pausa (PAUSA_EN) freezes counting.
module contador_regressivo_bcd
    import semaforo_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    contador_regressivo_bcd_if.slave    bus
);

    estado_cont_t estado;
    logic [3:0]   unid_q;
    logic [1:0]   dez_q;
    logic         ocupado_q;
    logic         fim_q;
    logic         pausado;
    logic         tick;

`ifdef PAUSA_EN
    assign pausado = bus.pausa;
`else
    assign pausado = 1'b0;
`endif

    gerador_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (bus.carrega),
        .enable ((estado == CONTANDO) && !pausado),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            unid_q    <= 4'd0;
            dez_q     <= 2'd0;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            if (bus.carrega) begin
                // Load beats a coincident tick and suppresses fim in any state.
                estado    <= CONTANDO;
                ocupado_q <= 1'b1;
                unid_q    <= sat_unid(bus.unid_preset);
                dez_q     <= bus.dez_preset;
            end else begin
                case (estado)
                    OCIOSO: begin
                        ocupado_q <= 1'b0;
                    end
                    CONTANDO: begin
                        if (tick) begin
                            if (unid_q != 4'd0) begin
                                unid_q <= unid_q - 4'd1;
                            end else if (dez_q != 2'd0) begin
                                unid_q <= BCD_MAX_UNID;
                                dez_q  <= dez_q - 2'd1;
                            end else begin
                                estado    <= FIM;
                                ocupado_q <= 1'b0;
                                fim_q     <= 1'b1;
                            end
                        end
                    end
                    FIM: begin
                        estado    <= OCIOSO;
                        ocupado_q <= 1'b0;
                    end
                    default: begin
                        estado    <= OCIOSO;
                        ocupado_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.unid    = unid_q;
    assign bus.dez     = dez_q;
    assign bus.ocupado = ocupado_q;
    assign bus.fim     = fim_q;

endmodule

// File: tb/tb_contador_regressivo_bcd.sv
// Bench for contador_regressivo_bcd: TICK_DIV=4 and TICK_DIV=1 instances against an integer-valued model.
// Directed scenarios with literal expectations, then random loads (and pausa when PAUSA_EN is defined).
module tb_contador_regressivo_bcd;

    logic       clk;
    logic       rst_n;
    logic       carrega;
    logic [3:0] unid_preset;
    logic [1:0] dez_preset;
`ifdef PAUSA_EN
    logic       pausa;
    wire        pz = pausa;
`else
    wire        pz = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    contador_regressivo_bcd_if bus4 ();
    contador_regressivo_bcd_if bus1 ();

    assign bus4.carrega     = carrega;
    assign bus4.unid_preset = unid_preset;
    assign bus4.dez_preset  = dez_preset;
    assign bus1.carrega     = carrega;
    assign bus1.unid_preset = unid_preset;
    assign bus1.dez_preset  = dez_preset;
`ifdef PAUSA_EN
    assign bus4.pausa = pausa;
    assign bus1.pausa = pausa;
`endif

    contador_regressivo_bcd #(.TICK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    contador_regressivo_bcd #(.TICK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the displayed time as one integer, a busy flag, and cycles since the last step.
    typedef struct {
        int val;
        bit busy;
        bit fim;
        int ph;
    } mdl_t;

    mdl_t m4, m1;

    function automatic mdl_t step(mdl_t m, bit ld, int up, int dp, bit p, int div);
        mdl_t n = m;
        n.fim = 0;
        if (ld) begin
            n.val  = ((up > 9) ? 9 : up) + 10 * dp;
            n.busy = 1;
            n.ph   = 0;
        end else if (m.busy && !p) begin
            if (m.ph == div - 1) begin
                n.ph = 0;
                if (m.val == 0) begin
                    n.busy = 0;
                    n.fim  = 1;
                end else begin
                    n.val = m.val - 1;
                end
            end else begin
                n.ph = m.ph + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m4 = '{0, 0, 0, 0};
            m1 = '{0, 0, 0, 0};
        end else begin
            m4 = step(m4, carrega, int'(unid_preset), int'(dez_preset), pz, 4);
            m1 = step(m1, carrega, int'(unid_preset), int'(dez_preset), pz, 1);
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            cmp("m4.unid", int'(bus4.unid), m4.val % 10);
            cmp("m4.dez", int'(bus4.dez), m4.val / 10);
            cmp("m4.ocupado", int'(bus4.ocupado), int'(m4.busy));
            cmp("m4.fim", int'(bus4.fim), int'(m4.fim));
            cmp("m1.unid", int'(bus1.unid), m1.val % 10);
            cmp("m1.dez", int'(bus1.dez), m1.val / 10);
            cmp("m1.ocupado", int'(bus1.ocupado), int'(m1.busy));
            cmp("m1.fim", int'(bus1.fim), int'(m1.fim));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int dz, input int un);
        carrega     = 1'b1;
        dez_preset  = 2'(dz);
        unid_preset = 4'(un);
        @(negedge clk);
        carrega = 1'b0;
    endtask

    task automatic pin4(input string nm, input int dz, input int un, input int oc, input int fm);
        cmp({nm, ".dez"}, int'(bus4.dez), dz);
        cmp({nm, ".unid"}, int'(bus4.unid), un);
        cmp({nm, ".ocupado"}, int'(bus4.ocupado), oc);
        cmp({nm, ".fim"}, int'(bus4.fim), fm);
    endtask

    initial begin
        int fims;
        rst_n       = 1'b0;
        carrega     = 1'b0;
        unid_preset = 4'd0;
        dez_preset  = 2'd0;
`ifdef PAUSA_EN
        pausa = 1'b0;
`endif
        cyc(2);
        pin4("reset", 0, 0, 0, 0);
        rst_n  = 1'b1;
        chk_en = 1;

        // 25 down to 00, then exactly one fim pulse.
        load(2, 5);
        pin4("load25", 2, 5, 1, 0);
        cyc(4);
        pin4("first_dec", 2, 4, 1, 0);
        fims = 0;
        for (int i = 0; i < 106; i++) begin
            cyc(1);
            if (bus4.fim) fims++;
        end
        cmp("fim_count", fims, 1);
        pin4("expired", 0, 0, 0, 0);

        // Borrow and preset saturation.
        load(1, 0);
        cyc(4);
        pin4("borrow", 0, 9, 1, 0);
        load(1, 12);
        pin4("sat_unid", 1, 9, 1, 0);

        // Preset 00 expires on the first tick.
        load(0, 0);
        cyc(3);
        pin4("zero_wait", 0, 0, 1, 0);
        cyc(1);
        pin4("zero_fim", 0, 0, 0, 1);
        cyc(1);
        pin4("zero_idle", 0, 0, 0, 0);

        // Reload coinciding with a tick at 13.
        load(1, 4);
        cyc(4);
        pin4("at13", 1, 3, 1, 0);
        cyc(3);
        load(3, 0);
        pin4("reload30", 3, 0, 1, 0);
        cyc(3);
        pin4("reload_hold", 3, 0, 1, 0);
        cyc(1);
        pin4("reload_dec", 2, 9, 1, 0);

        // Asynchronous reset mid-count, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1 pin4("arst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef PAUSA_EN
        load(0, 7);
        pausa = 1'b1;
        cyc(10);
        pin4("paused", 0, 7, 1, 0);
        pausa = 1'b0;
        cyc(3);
        pin4("resume_hold", 0, 7, 1, 0);
        cyc(1);
        pin4("resume_dec", 0, 6, 1, 0);
`endif

        // TICK_DIV=1 instance steps every cycle.
        load(0, 3);
        cmp("div1.load", int'(bus1.unid), 3);
        cyc(1);
        cmp("div1.02", int'(bus1.unid), 2);
        cyc(1);
        cmp("div1.01", int'(bus1.unid), 1);
        cyc(1);
        cmp("div1.00", int'(bus1.unid), 0);
        cmp("div1.00.fim", int'(bus1.fim), 0);
        cyc(1);
        cmp("div1.fim", int'(bus1.fim), 1);
        cmp("div1.ocupado", int'(bus1.ocupado), 0);

        for (int i = 0; i < 1500; i++) begin
            carrega     = ($urandom_range(0, 29) == 0);
            unid_preset = 4'($urandom_range(0, 15));
            dez_preset  = 2'($urandom_range(0, 3));
`ifdef PAUSA_EN
            pausa = ($urandom_range(0, 7) == 0);
`endif
            cyc(1);
        end
        carrega = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
